// File: rtl/gpr_mp.sv
// Multi-port general-purpose register file: x0 hardwired to zero, same-cycle write bypass,
// pending-write scoreboard and a one-register-per-cycle bulk-clear sweep.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module gpr_mp #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int GPRS_NUM   = 32,
  parameter int GPRS_WIDTH = $clog2(GPRS_NUM),
  parameter int RD_PORTS   = 3,
  parameter int WR_PORTS   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           i_sys_clk,
  input  logic                           i_sys_rst_n,
  input  logic [RD_PORTS*GPRS_WIDTH-1:0] i_gpr_rd_id,
  output logic [RD_PORTS*DATA_WIDTH-1:0] o_gpr_rd_data,
  output logic [RD_PORTS-1:0]            o_gpr_rd_busy,
  input  logic [WR_PORTS-1:0]            i_gpr_wr_en,
  input  logic [WR_PORTS*GPRS_WIDTH-1:0] i_gpr_wr_id,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] i_gpr_wr_data,
  input  logic                           i_gpr_sb_set_en,
  input  logic [GPRS_WIDTH-1:0]          i_gpr_sb_set_id,
  output logic [GPRS_NUM-1:0]            o_gpr_sb_busy,
  input  logic                           i_gpr_clr_req,
  output logic                           o_gpr_clr_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [GPRS_WIDTH:0]   L_NUM  = (GPRS_WIDTH+1)'(GPRS_NUM);
  localparam logic [GPRS_WIDTH-1:0] L_LAST = GPRS_WIDTH'(GPRS_NUM - 1);

  state_t                  r_state;
  logic [GPRS_WIDTH-1:0]   r_idx;
  logic                    r_clr_busy;
  logic [DATA_WIDTH-1:0]   r_gpr [1:GPRS_NUM-1];
  logic [GPRS_NUM-1:0]     r_sb;
  logic [GPRS_NUM-1:0]     w_sb_next;
  logic [WR_PORTS-1:0]     w_wr_ok;
  logic [RD_PORTS*DATA_WIDTH-1:0] w_rd_data;
  logic [RD_PORTS-1:0]     w_rd_busy;

  // A write is honoured only outside the sweep, to a non-zero in-range index.
  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (r_state == ST_IDLE && i_gpr_wr_en[p] &&
          i_gpr_wr_id[p*GPRS_WIDTH +: GPRS_WIDTH] != '0 &&
          {1'b0, i_gpr_wr_id[p*GPRS_WIDTH +: GPRS_WIDTH]} < L_NUM) begin
        w_wr_ok[p] = 1'b1;
      end else begin
        w_wr_ok[p] = 1'b0;
      end
    end
  end

  // Bulk-clear sequencer.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_gpr_clr_req) begin
            r_state    <= ST_CLEAR;
            r_idx      <= GPRS_WIDTH'(1);
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_idx == L_LAST) begin
            r_state    <= ST_IDLE;
            r_clr_busy <= 1'b0;
          end else begin
            r_idx <= r_idx + GPRS_WIDTH'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage: later write ports override earlier ones on an index collision.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      for (int i = 1; i < GPRS_NUM; i++) r_gpr[i] <= '0;
    end else begin
      for (int i = 1; i < GPRS_NUM; i++) begin
        if (r_state == ST_CLEAR) begin
          if (r_idx == GPRS_WIDTH'(i)) r_gpr[i] <= '0;
        end else begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (w_wr_ok[p] && i_gpr_wr_id[p*GPRS_WIDTH +: GPRS_WIDTH] == GPRS_WIDTH'(i))
              r_gpr[i] <= i_gpr_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Scoreboard next state: a same-cycle set beats a writeback clear.
  always_comb begin
    w_sb_next = r_sb;
    if (r_state == ST_IDLE) begin
      if (i_gpr_clr_req) begin
        w_sb_next = '0;
      end else begin
        for (int i = 1; i < GPRS_NUM; i++) begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (w_wr_ok[p] && i_gpr_wr_id[p*GPRS_WIDTH +: GPRS_WIDTH] == GPRS_WIDTH'(i))
              w_sb_next[i] = 1'b0;
          end
          if (i_gpr_sb_set_en && i_gpr_sb_set_id == GPRS_WIDTH'(i)) w_sb_next[i] = 1'b1;
        end
      end
    end else begin
      w_sb_next = r_sb;
    end
    w_sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) r_sb <= '0;
    else              r_sb <= w_sb_next;
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int i = 1; i < GPRS_NUM; i++) begin
        if (i_gpr_rd_id[p*GPRS_WIDTH +: GPRS_WIDTH] == GPRS_WIDTH'(i)) begin
          w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_gpr[i];
          w_rd_busy[p] = r_sb[i];
        end
      end
      if (BYPASS != 0) begin
        for (int q = 0; q < WR_PORTS; q++) begin
          if (w_wr_ok[q] && i_gpr_wr_id[q*GPRS_WIDTH +: GPRS_WIDTH] == i_gpr_rd_id[p*GPRS_WIDTH +: GPRS_WIDTH])
            w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = i_gpr_wr_data[q*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign o_gpr_rd_data  = w_rd_data;
  assign o_gpr_rd_busy  = w_rd_busy;
  assign o_gpr_sb_busy  = r_sb;
  assign o_gpr_clr_busy = r_clr_busy;

endmodule
